// File: rtl/pid_controller_multi.sv
// Time-multiplexed PID controller: one shared multiplier serves NUM_CHANNELS channels per sweep.
// Define PID_SLEW_LIMIT_EN to add a per-channel output slew limit (config address 11).
module pid_controller_multi #(
  parameter int NUM_CHANNELS = 6,
  parameter int DATA_W       = 32,
  parameter int GAIN_W       = 16,
  parameter int OUT_W        = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              update_controller,
  input  logic [NUM_CHANNELS*DATA_W-1:0]    position,
  input  logic [NUM_CHANNELS*16-1:0]        velocity,
  input  logic [NUM_CHANNELS*16-1:0]        displacement,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0]   cfg_channel,
  input  logic [3:0]                        cfg_addr,
  input  logic [DATA_W-1:0]                 cfg_data,
  output logic                              cfg_ready,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_CHANNELS*OUT_W-1:0]     pwmRef
);

  localparam int ACC_W = DATA_W + GAIN_W + 2;
  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_P, S_I, S_D, S_FF, S_SUM} state_t;

  state_t          state, state_next;
  logic [CH_W-1:0] ch, ch_next;
  logic            upd_q, upd_prev, start, cfg_accept;

  logic signed [GAIN_W-1:0] kp [NUM_CHANNELS];
  logic signed [GAIN_W-1:0] ki [NUM_CHANNELS];
  logic signed [GAIN_W-1:0] kd [NUM_CHANNELS];
  logic signed [GAIN_W-1:0] kf [NUM_CHANNELS];
  logic signed [DATA_W-1:0] out_pos [NUM_CHANNELS];
  logic signed [DATA_W-1:0] out_neg [NUM_CHANNELS];
  logic signed [DATA_W-1:0] int_pos [NUM_CHANNELS];
  logic signed [DATA_W-1:0] int_neg [NUM_CHANNELS];
  logic signed [DATA_W-1:0] dead_band [NUM_CHANNELS];
  logic signed [DATA_W-1:0] sp [NUM_CHANNELS];
  logic [1:0]               mode [NUM_CHANNELS];
  logic signed [DATA_W-1:0] integral [NUM_CHANNELS];
  logic signed [DATA_W-1:0] last_err [NUM_CHANNELS];
  logic signed [OUT_W-1:0]  pwm [NUM_CHANNELS];
`ifdef PID_SLEW_LIMIT_EN
  logic signed [DATA_W-1:0] slew_max [NUM_CHANNELS];
  logic signed [ACC_W-1:0]  prev_out, delta, step;
`endif

  logic signed [DATA_W-1:0] cur_pos, err, err_q;
  logic signed [15:0]       cur_vel;
  logic [15:0]              cur_disp;
  logic                     disp_unused;
  logic signed [DATA_W:0]   err_mag;
  logic                     in_db_c, in_db, off, pterm_ok;
  logic signed [GAIN_W-1:0] mul_a;
  logic signed [DATA_W:0]   mul_b;
  logic signed [ACC_W-1:0]  prod, pterm, dterm, ffterm, int_acc, out_sum, out_clamped, out_final;

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] v,
                                                    input logic signed [DATA_W-1:0] lo,
                                                    input logic signed [DATA_W-1:0] hi);
    if (v < ACC_W'(lo)) clamp = ACC_W'(lo);
    else if (v > ACC_W'(hi)) clamp = ACC_W'(hi);
    else clamp = v;
  endfunction

  assign start      = upd_q & ~upd_prev;
  assign cfg_ready  = ~busy;
  assign cfg_accept = cfg_we && !busy && ({1'b0, cfg_channel} < (CH_W+1)'(NUM_CHANNELS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upd_q    <= 1'b0;
      upd_prev <= 1'b0;
    end else begin
      upd_q    <= update_controller;
      upd_prev <= upd_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ch    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ch    <= ch_next;
      busy  <= (state_next != S_IDLE);
      done  <= (state == S_SUM) && (ch == LAST_CH);
    end
  end

  always_comb begin
    state_next = state;
    ch_next    = ch;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ERR;
          ch_next    = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ERR: state_next = S_P;
      S_P:   state_next = S_I;
      S_I:   state_next = S_D;
      S_D:   state_next = S_FF;
      S_FF:  state_next = S_SUM;
      S_SUM: begin
        if (ch == LAST_CH) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_ERR;
          ch_next    = ch + CH_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Error for the channel in service; displacement is a 15-bit signed field.
  always_comb begin
    cur_pos     = $signed(position[int'(ch)*DATA_W +: DATA_W]);
    cur_vel     = $signed(velocity[int'(ch)*16 +: 16]);
    cur_disp    = displacement[int'(ch)*16 +: 16];
    disp_unused = cur_disp[15];
    err         = '0;
    case (mode[ch])
      2'd0: err = sp[ch] - cur_pos;
      2'd1: err = sp[ch] - DATA_W'(cur_vel);
      2'd2: begin
        if (!cur_disp[14] && !sp[ch][DATA_W-1] && (sp[ch] != '0)) err = sp[ch] - DATA_W'(cur_disp[13:0]);
        else err = '0;
      end
      default: err = '0;
    endcase
    err_mag = err[DATA_W-1] ? -((DATA_W+1)'(err)) : (DATA_W+1)'(err);
    in_db_c = err_mag < (DATA_W+1)'(dead_band[ch]);
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_P:  begin mul_a = kp[ch]; mul_b = (DATA_W+1)'(err_q); end
      S_I:  begin mul_a = ki[ch]; mul_b = (DATA_W+1)'(err_q); end
      S_D:  begin mul_a = kd[ch]; mul_b = (DATA_W+1)'(err_q) - (DATA_W+1)'(last_err[ch]); end
      S_FF: begin mul_a = kf[ch]; mul_b = (DATA_W+1)'(sp[ch]); end
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  assign prod = ACC_W'(mul_a) * ACC_W'(mul_b);

  // Anti-windup window, integral update and output shaping.
  always_comb begin
    pterm_ok    = (pterm > ACC_W'(out_neg[ch])) && (pterm < ACC_W'(out_pos[ch]));
    int_acc     = clamp(ACC_W'(integral[ch]) + prod, int_neg[ch], int_pos[ch]);
    out_sum     = pterm + ACC_W'(integral[ch]) + dterm + ffterm;
    out_clamped = in_db ? clamp(ACC_W'(integral[ch]), out_neg[ch], out_pos[ch])
                        : clamp(out_sum, out_neg[ch], out_pos[ch]);
`ifdef PID_SLEW_LIMIT_EN
    prev_out = ACC_W'(pwm[ch]);
    delta    = out_clamped - prev_out;
    step     = ACC_W'(slew_max[ch]);
    if (step == '0) out_final = out_clamped;
    else if (delta > step) out_final = prev_out + step;
    else if (delta < -step) out_final = prev_out - step;
    else out_final = out_clamped;
`else
    out_final = out_clamped;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q  <= '0;
      in_db  <= 1'b0;
      off    <= 1'b0;
      pterm  <= '0;
      dterm  <= '0;
      ffterm <= '0;
    end else begin
      case (state)
        S_ERR: begin
          err_q <= err;
          in_db <= in_db_c;
          off   <= (mode[ch] == 2'd3);
        end
        S_P:  pterm  <= prod;
        S_D:  dterm  <= prod;
        S_FF: ffterm <= prod;
        default: ;
      endcase
    end
  end

  // Config writes only land while idle, so they never collide with sweep updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        kp[c] <= '0; ki[c] <= '0; kd[c] <= '0; kf[c] <= '0;
        out_pos[c] <= '0; out_neg[c] <= '0; int_pos[c] <= '0; int_neg[c] <= '0;
        dead_band[c] <= '0; sp[c] <= '0; mode[c] <= 2'd0;
        integral[c] <= '0; last_err[c] <= '0; pwm[c] <= '0;
`ifdef PID_SLEW_LIMIT_EN
        slew_max[c] <= '0;
`endif
      end
    end else if (cfg_accept) begin
      case (cfg_addr)
        4'd0:  kp[cfg_channel]        <= cfg_data[GAIN_W-1:0];
        4'd1:  ki[cfg_channel]        <= cfg_data[GAIN_W-1:0];
        4'd2:  kd[cfg_channel]        <= cfg_data[GAIN_W-1:0];
        4'd3:  kf[cfg_channel]        <= cfg_data[GAIN_W-1:0];
        4'd4:  out_pos[cfg_channel]   <= cfg_data;
        4'd5:  out_neg[cfg_channel]   <= cfg_data;
        4'd6:  int_pos[cfg_channel]   <= cfg_data;
        4'd7:  int_neg[cfg_channel]   <= cfg_data;
        4'd8:  dead_band[cfg_channel] <= cfg_data;
        4'd9:  sp[cfg_channel]        <= cfg_data;
        4'd10: begin
          mode[cfg_channel]     <= cfg_data[1:0];
          integral[cfg_channel] <= '0;
          last_err[cfg_channel] <= '0;
        end
`ifdef PID_SLEW_LIMIT_EN
        4'd11: slew_max[cfg_channel] <= cfg_data;
`endif
        default: ;
      endcase
    end else begin
      case (state)
        S_I: begin
          if (off) integral[ch] <= '0;
          else if (!in_db && pterm_ok) integral[ch] <= DATA_W'(int_acc);
          else integral[ch] <= integral[ch];
        end
        S_D:   last_err[ch] <= off ? '0 : err_q;
        S_SUM: pwm[ch] <= off ? '0 : OUT_W'(out_final);
        default: ;
      endcase
    end
  end

  always_comb begin
    pwmRef = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) pwmRef[c*OUT_W +: OUT_W] = pwm[c];
  end

endmodule

// File: tb/tb_pid_controller_multi.sv
// Self-checking bench for pid_controller_multi against a sweep-level arithmetic model.
module tb_pid_controller_multi;
  localparam int N = 6, DW = 32, OW = 16;

  logic clock = 1'b0;
  logic reset, update_controller, cfg_we, cfg_ready, busy, done;
  logic [N*DW-1:0] position;
  logic [N*16-1:0] velocity, displacement;
  logic [2:0] cfg_channel;
  logic [3:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [N*OW-1:0] pwmRef;

  int checks = 0, failures = 0;

  longint m_kp[N], m_ki[N], m_kd[N], m_kf[N], m_opos[N], m_oneg[N], m_ipos[N], m_ineg[N];
  longint m_db[N], m_sp[N], m_int[N], m_last[N], m_pwm[N];
  int m_mode[N];
  longint pos_v[N], vel_v[N];
  logic [15:0] disp_v[N];

  pid_controller_multi dut (
    .clock(clock), .reset(reset), .update_controller(update_controller),
    .position(position), .velocity(velocity), .displacement(displacement),
    .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .busy(busy), .done(done), .pwmRef(pwmRef)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint lim(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_kf[c] = 0; m_opos[c] = 0; m_oneg[c] = 0;
      m_ipos[c] = 0; m_ineg[c] = 0; m_db[c] = 0; m_sp[c] = 0; m_mode[c] = 0;
      m_int[c] = 0; m_last[c] = 0; m_pwm[c] = 0;
    end
  endtask

  task automatic model_cfg(input int c, input int a, input logic [31:0] d);
    case (a)
      0: m_kp[c] = longint'($signed(d[15:0]));
      1: m_ki[c] = longint'($signed(d[15:0]));
      2: m_kd[c] = longint'($signed(d[15:0]));
      3: m_kf[c] = longint'($signed(d[15:0]));
      4: m_opos[c] = longint'($signed(d));
      5: m_oneg[c] = longint'($signed(d));
      6: m_ipos[c] = longint'($signed(d));
      7: m_ineg[c] = longint'($signed(d));
      8: m_db[c] = longint'($signed(d));
      9: m_sp[c] = longint'($signed(d));
      10: begin m_mode[c] = int'(d[1:0]); m_int[c] = 0; m_last[c] = 0; end
      default: ;
    endcase
  endtask

  // One full sweep of the PID rules over every channel.
  task automatic model_sweep();
    for (int c = 0; c < N; c++) begin
      longint e, p, mag;
      logic signed [14:0] d15;
      d15 = disp_v[c][14:0];
      if (m_mode[c] == 3) begin
        m_pwm[c] = 0; m_int[c] = 0; m_last[c] = 0;
      end else begin
        if (m_mode[c] == 0) e = m_sp[c] - pos_v[c];
        else if (m_mode[c] == 1) e = m_sp[c] - vel_v[c];
        else e = (d15 >= 0 && m_sp[c] > 0) ? m_sp[c] - longint'(d15) : 0;
        mag = (e < 0) ? -e : e;
        if (mag < m_db[c]) begin
          m_pwm[c] = lim(m_int[c], m_oneg[c], m_opos[c]);
        end else begin
          p = m_kp[c] * e;
          if (p > m_oneg[c] && p < m_opos[c]) m_int[c] = lim(m_int[c] + m_ki[c] * e, m_ineg[c], m_ipos[c]);
          m_pwm[c] = lim(p + m_int[c] + m_kd[c] * (e - m_last[c]) + m_kf[c] * m_sp[c], m_oneg[c], m_opos[c]);
        end
        m_last[c] = e;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < N; c++) begin
      position[c*DW +: DW] = DW'(pos_v[c]);
      velocity[c*16 +: 16] = 16'(vel_v[c]);
      displacement[c*16 +: 16] = disp_v[c];
    end
  endtask

  task automatic cfg_write(input int c, input int a, input longint d);
    @(negedge clock);
    cfg_we = 1'b1; cfg_channel = 3'(c); cfg_addr = 4'(a); cfg_data = 32'(d);
    @(negedge clock);
    cfg_we = 1'b0;
    model_cfg(c, a, 32'(d));
  endtask

  task automatic cfg_limits(input int c);
    cfg_write(c, 4, 1000); cfg_write(c, 5, -1000);
    cfg_write(c, 6, 1000); cfg_write(c, 7, -1000);
  endtask

  // Runs one sweep, measuring busy length and done pulses (bounded waits).
  task automatic run_sweep(output int bc, output int dc);
    int guard;
    bc = 0; dc = 0; guard = 0;
    drive_inputs();
    @(negedge clock);
    update_controller = 1'b1;
    while (!busy && guard < 20) begin @(negedge clock); guard++; end
    while (busy && guard < 200) begin
      bc++;
      if (done) dc++;
      @(negedge clock); guard++;
    end
    if (done) dc++;
    @(negedge clock);
    if (done) dc++;
    update_controller = 1'b0;
    model_sweep();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pwmRef !== '0) begin
      failures++;
      $display("FAIL reset_hold: busy=%b done=%b pwmRef=%h, required 0/0/0", busy, done, pwmRef);
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || pwmRef !== '0) begin
      failures++;
      $display("FAIL reset_release: cfg_ready=%b busy=%b pwmRef=%h, required 1/0/0", cfg_ready, busy, pwmRef);
    end
  endtask

  task automatic test_gain_path();
    int bc, dc;
    cfg_write(0, 0, 2); cfg_write(0, 9, 100); cfg_limits(0);
    pos_v[0] = 40;
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[OW-1:0] !== 16'd120) begin
      failures++; $display("FAIL gain_ch0: got %0d, required 120", $signed(pwmRef[OW-1:0]));
    end
    checks++;
    if (pwmRef[N*OW-1:OW] !== '0) begin
      failures++; $display("FAIL gain_others: got %h, required 0", pwmRef[N*OW-1:OW]);
    end
    checks++;
    if (bc != 36 || dc != 1) begin
      failures++; $display("FAIL sweep_timing: busy=%0d done=%0d, required 36 and 1", bc, dc);
    end
  endtask

  task automatic test_antiwindup();
    int bc, dc;
    cfg_write(0, 0, 100); cfg_write(0, 1, 1); cfg_write(0, 10, 0);
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[OW-1:0] !== 16'd1000) begin
      failures++; $display("FAIL clamp_pos: got %0d, required 1000", $signed(pwmRef[OW-1:0]));
    end
    cfg_write(0, 0, 0);
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[OW-1:0] !== 16'd60) begin
      failures++; $display("FAIL antiwindup: got %0d, required 60", $signed(pwmRef[OW-1:0]));
    end
  endtask

  task automatic test_deadband();
    int bc, dc;
    cfg_write(1, 1, 1); cfg_write(1, 9, 30); cfg_limits(1);
    pos_v[1] = 0;
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[2*OW-1:OW] !== 16'd30) begin
      failures++; $display("FAIL db_build: got %0d, required 30", $signed(pwmRef[2*OW-1:OW]));
    end
    cfg_write(1, 8, 10); cfg_write(1, 9, 5);
    for (int k = 0; k < 2; k++) begin
      run_sweep(bc, dc);
      checks++;
      if (pwmRef[2*OW-1:OW] !== 16'd30) begin
        failures++; $display("FAIL db_hold sweep %0d: got %0d, required 30", k, $signed(pwmRef[2*OW-1:OW]));
      end
    end
  endtask

  task automatic test_displacement();
    int bc, dc;
    cfg_write(2, 10, 2); cfg_write(2, 0, 1); cfg_write(2, 9, 50); cfg_limits(2);
    disp_v[2] = 16'h7FF0;
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[3*OW-1:2*OW] !== 16'd0) begin
      failures++; $display("FAIL disp_neg: got %0d, required 0", $signed(pwmRef[3*OW-1:2*OW]));
    end
    disp_v[2] = 16'd20;
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[3*OW-1:2*OW] !== 16'd30) begin
      failures++; $display("FAIL disp_pos: got %0d, required 30", $signed(pwmRef[3*OW-1:2*OW]));
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc, guard, late;
    logic [OW-1:0] exp_v;
    bc = 0; dc = 0; guard = 0; late = 0;
    drive_inputs();
    @(negedge clock);
    update_controller = 1'b1;
    while (!busy && guard < 20) begin @(negedge clock); guard++; end
    while (busy && guard < 200) begin
      bc++;
      if (done) dc++;
      if (bc == 5) begin cfg_we = 1'b1; cfg_channel = 3'd0; cfg_addr = 4'd0; cfg_data = 32'd1000; end
      else cfg_we = 1'b0;
      if (bc == 10) update_controller = 1'b0;
      if (bc == 12) update_controller = 1'b1;
      @(negedge clock); guard++;
    end
    cfg_we = 1'b0;
    if (done) dc++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy) late++;
      if (done) dc++;
    end
    update_controller = 1'b0;
    model_sweep();
    checks++;
    if (bc != 36 || dc != 1 || late != 0) begin
      failures++; $display("FAIL dropped_edge: busy=%0d done=%0d late=%0d, required 36/1/0", bc, dc, late);
    end
    run_sweep(bc, dc);
    exp_v = OW'(m_pwm[0]);
    checks++;
    if (pwmRef[OW-1:0] !== exp_v) begin
      failures++; $display("FAIL busy_write_ignored: got %0d, required %0d", $signed(pwmRef[OW-1:0]), $signed(exp_v));
    end
  endtask

  task automatic test_random();
    int bc, dc;
    logic [OW-1:0] exp_v;
    for (int c = 0; c < N; c++) begin
      cfg_write(c, 0, int'($urandom_range(40)) - 20);
      cfg_write(c, 1, int'($urandom_range(10)) - 5);
      cfg_write(c, 2, int'($urandom_range(10)) - 5);
      cfg_write(c, 3, int'($urandom_range(6)) - 3);
      cfg_write(c, 4, int'($urandom_range(20000)));
      cfg_write(c, 5, -int'($urandom_range(20000)));
      cfg_write(c, 6, int'($urandom_range(5000)));
      cfg_write(c, 7, -int'($urandom_range(5000)));
      cfg_write(c, 8, int'($urandom_range(40)));
      cfg_write(c, 9, int'($urandom_range(1000)) - 500);
      cfg_write(c, 10, (c == 5) ? 3 : int'($urandom_range(3)));
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < N; c++) begin
        pos_v[c] = int'($urandom_range(1000)) - 500;
        vel_v[c] = int'($urandom_range(1000)) - 500;
        disp_v[c] = 16'($urandom);
      end
      run_sweep(bc, dc);
      for (int c = 0; c < N; c++) begin
        exp_v = OW'(m_pwm[c]);
        checks++;
        if (pwmRef[c*OW +: OW] !== exp_v) begin
          failures++;
          $display("FAIL random s%0d ch%0d mode%0d: got %0d, required %0d", s, c, m_mode[c],
                   $signed(pwmRef[c*OW +: OW]), $signed(exp_v));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc, guard;
    for (int c = 0; c < N; c++) cfg_write(c, 10, 0);
    cfg_write(0, 0, 0); cfg_write(0, 1, 1); cfg_write(0, 2, 0); cfg_write(0, 3, 0);
    cfg_write(0, 8, 0); cfg_write(0, 9, 100); cfg_limits(0);
    pos_v[0] = 40;
    run_sweep(bc, dc);
    guard = 0;
    @(negedge clock);
    update_controller = 1'b1;
    while (!busy && guard < 20) begin @(negedge clock); guard++; end
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pwmRef !== '0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b ready=%b pwmRef=%h, required 0/0/1/0", busy, done, cfg_ready, pwmRef);
    end
    @(negedge clock);
    update_controller = 1'b0;
    reset = 1'b0;
    cfg_write(0, 1, 1); cfg_write(0, 9, 100); cfg_limits(0);
    run_sweep(bc, dc);
    checks++;
    if (pwmRef[OW-1:0] !== 16'd60 || bc != 36 || dc != 1) begin
      failures++;
      $display("FAIL post_reset_sweep: pwm0=%0d busy=%0d done=%0d, required 60/36/1", $signed(pwmRef[OW-1:0]), bc, dc);
    end
  endtask

  initial begin
    reset = 1'b1; update_controller = 1'b0; cfg_we = 1'b0;
    cfg_channel = 3'd0; cfg_addr = 4'd0; cfg_data = 32'd0;
    for (int c = 0; c < N; c++) begin pos_v[c] = 0; vel_v[c] = 0; disp_v[c] = 16'd0; end
    model_reset();
    drive_inputs();
    repeat (3) @(negedge clock);
    test_reset();
    test_gain_path();
    test_antiwindup();
    test_deadband();
    test_displacement();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pid_controller_multi.md
Name: pid_controller_multi

Overview:
- Time-multiplexed PID controller serving NUM_CHANNELS muscle motor channels from one shared multiply datapath.
- Each channel has its own gains, limits, setpoint and mode (position / velocity / displacement / off), plus its own integral and last-error state.
- A rising edge on update_controller starts one sweep over all channels. Each channel's pwm output is refreshed in turn.
- Sits between the SPI/encoder feedback registers and the PWM output stage. Replaces the single-channel controller.

Parameters:
- NUM_CHANNELS, 6: number of channels served per sweep.
- DATA_W, 32: width of setpoint, position, error, integral and config words.
- GAIN_W, 16: width of the Kp/Ki/Kd/forwardGain fields.
- OUT_W, 16: width of each pwmRef output.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- update_controller  in  1  a rising edge starts a sweep.
- position  in  NUM_CHANNELS*DATA_W  signed position per channel; channel c occupies slice [c*DATA_W +: DATA_W].
- velocity  in  NUM_CHANNELS*16  signed velocity per channel.
- displacement  in  NUM_CHANNELS*16  raw spring displacement per channel.
- cfg_we  in  1  config write strobe.
- cfg_channel  in  $clog2(NUM_CHANNELS)  target channel for the write.
- cfg_addr  in  4  config register select.
- cfg_data  in  DATA_W  write data.
- cfg_ready  out  1  writes are accepted only while high; equals !busy.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse at the end of a sweep.
- pwmRef  out  NUM_CHANNELS*OUT_W  signed output per channel.

Behaviour:
- Reset: all outputs 0, all config registers 0, all integral and lastError state 0, FSM in IDLE, edge detector cleared.
- Config map (low bits of cfg_data used for narrow fields):
  - 0 Kp, 1 Ki, 2 Kd, 3 forwardGain.
  - 4 outputPosMax, 5 outputNegMax, 6 integralPosMax, 7 integralNegMax.
  - 8 deadBand, 9 sp, 10 mode[1:0], 11 slewMax (optional feature only).
  - A write to address 10 also clears that channel's integral and lastError.
  - Writes with cfg_ready low, or with cfg_channel >= NUM_CHANNELS, are ignored.
- Edge detection: update_controller is registered. A start occurs when the current sample is 1 and the previous sample was 0. A start seen while busy is dropped, not queued.
- FSM: IDLE -> ERR -> P -> I -> D -> FF -> SUM, then either ERR of the next channel, or IDLE once the last channel is done.
  - Exactly 6 cycles per channel.
  - busy is high for exactly 6*NUM_CHANNELS cycles, starting the cycle after the start is detected.
- ERR (error calculation per mode):
  - mode 0: err = sp - position.
  - mode 1: err = sp - sign-extended velocity.
  - mode 2: d = $signed(displacement[14:0]). If d >= 0 and sp > 0, err = sp - d; otherwise err = 0.
  - mode 3: channel is off. pwmRef = 0, integral and lastError are cleared, and the remaining stages are no-ops.
- Arithmetic and deadband:
  - Products and sums use ACC_W = DATA_W + GAIN_W + 2 bits, signed.
  - If |err| < deadBand, the channel output is the integral clamped to [outputNegMax, outputPosMax].
  - Otherwise:
    - pterm = Kp*err.
    - The integral accumulates Ki*err only if outputNegMax < pterm < outputPosMax. After accumulating, it is clamped to [integralNegMax, integralPosMax].
    - dterm = Kd*(err - lastError).
    - ffterm = forwardGain*sp.
    - The sum of the four terms is clamped to [outputNegMax, outputPosMax].
- lastError <= err for every processed channel, including deadband cases.
- Each pwmRef slice updates at the end of its channel's SUM cycle. All other slices hold their values.
- done rises in the cycle busy falls.
- Config registers are stable during a sweep because cfg_ready is low while busy.

Optional Feature:
- Macro: PID_SLEW_LIMIT_EN.
- Defined:
  - Per-channel slewMax register at address 11.
  - After the output clamp, |new - previous pwmRef| is limited to slewMax per sweep.
  - slewMax = 0 disables limiting for that channel.
  - Mode 3 still forces pwmRef to 0 immediately.
- Undefined: address 11 writes are ignored and the output is the clamped sum only.

Test Plan:
- Gain path: ch0 mode 0, Kp=2, sp=100, position=40, other gains 0, limits ±1000 -> pwmRef[0]=120 after one sweep; the other channels stay 0.
- Output clamp and anti-windup: Kp=100, Ki=1, err=60 -> pwmRef=1000 and integral stays 0. Then Kp=0 -> pwmRef=60 on the next sweep.
- Deadband: Ki=1, integral built to 30, then deadBand=10 with err=5 -> pwmRef=30; integral unchanged.
- Displacement mode: mode 2, sp=50, displacement=16'h7FF0 (negative) -> err=0. With displacement=20 and Kp=1 -> pwmRef=30.
- Timing and handshake:
  - NUM_CHANNELS=6: busy is high for 36 cycles and done pulses once.
  - A second rising edge mid-sweep is dropped.
  - A cfg write during busy is ignored.
- Reset mid-sweep: assert reset at cycle 10 -> busy=0, done=0, all pwmRef=0, integrals 0. The next edge starts a clean sweep.
